// File: rtl/mp_addsub_limb_if.sv
// Request/response bundle of the multi-precision adder/subtractor.
// The master drives operands and commands; the slave returns the result and status.
interface mp_addsub_limb_if #(
  parameter int unsigned WIDTH = 514
);
  logic             start;
  logic [1:0]       mode;
  logic             shift;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   result;
  logic             busy;
  logic             done;
  logic             sub_taken;

  modport master (
    output start, mode, shift, in_a, in_b,
    input  result, busy, done, sub_taken
  );

  modport slave (
    input  start, mode, shift, in_a, in_b,
    output result, busy, done, sub_taken
  );
endinterface

// File: rtl/mp_addsub_limb.sv
// Limb-serial multi-precision add / subtract / conditional-subtract, LSB limb first.
// The carry (or borrow) between limbs is held in a register. The result can be shifted right by one in place.
module mp_addsub_limb #(
  parameter int unsigned WIDTH = 514,
  parameter int unsigned LIMB  = 64
) (
  input  logic            clk,
  input  logic            resetn,
  mp_addsub_limb_if.slave bus
);

  localparam int unsigned NLIMB = (WIDTH + LIMB) / LIMB;
  localparam int unsigned NW    = NLIMB * LIMB;
  localparam int unsigned LW    = LIMB + 1;
  localparam int unsigned RW    = WIDTH + 1;
  localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          r_state;
  logic [NW-1:0]   r_a;
  logic [NW-1:0]   r_b;
  logic [NW-1:0]   r_acc;
  logic            r_carry;
  logic            r_sub;
  logic            r_cond;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_result;
  logic            r_busy;
  logic            r_done;
  logic            r_sub_taken;

  logic            w_sub_mode;
  logic            w_cond_mode;
  logic            w_last;
  logic [LIMB-1:0] w_b_limb;
  logic [LW-1:0]   w_sum;
  logic [NW-1:0]   w_a_rot;
  logic [NW-1:0]   w_b_nxt;
  logic [NW-1:0]   w_acc_nxt;
  logic [RW-1:0]   w_fin_result;

  assign w_sub_mode  = (bus.mode == 2'b01) || (bus.mode == 2'b10);
  assign w_cond_mode = (bus.mode == 2'b10);
  assign w_last      = (r_cnt == CW'(NLIMB - 1));

  // One limb of A + (B or ~B) + carry; the subtract +1 enters as the initial carry.
  assign w_b_limb = r_b[LIMB-1:0] ^ {LIMB{r_sub}};
  assign w_sum    = LW'(r_a[LIMB-1:0]) + LW'(w_b_limb) + LW'(r_carry);

  // A rotates so it is intact again after NLIMB steps, for the conditional-subtract fallback.
  if (NLIMB > 1) begin : g_multi
    assign w_a_rot   = {r_a[LIMB-1:0], r_a[NW-1:LIMB]};
    assign w_b_nxt   = {{LIMB{1'b0}}, r_b[NW-1:LIMB]};
    assign w_acc_nxt = {w_sum[LIMB-1:0], r_acc[NW-1:LIMB]};
  end else begin : g_single
    assign w_a_rot   = r_a;
    assign w_b_nxt   = r_b;
    assign w_acc_nxt = w_sum[LIMB-1:0];
  end

  // The final carry-out over NW bits is set exactly when A >= B in subtract modes.
  assign w_fin_result = (r_cond && !r_carry) ? r_a[RW-1:0] : r_acc[RW-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_cond      <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sub_taken <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a         <= NW'(bus.in_a);
            r_b         <= NW'(bus.in_b);
            r_sub       <= w_sub_mode;
            r_carry     <= w_sub_mode;
            r_cond      <= w_cond_mode;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_sub_taken <= 1'b0;
            r_state     <= S_RUN;
          end else if (bus.shift) begin
            r_result <= {1'b0, r_result[RW-1:1]};
          end
        end
        S_RUN: begin
          r_a     <= w_a_rot;
          r_b     <= w_b_nxt;
          r_acc   <= w_acc_nxt;
          r_carry <= w_sum[LIMB];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_result    <= w_fin_result;
          r_sub_taken <= r_cond && r_carry;
          r_done      <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result    = r_result;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sub_taken = r_sub_taken;

endmodule

// File: tb/tb_mp_addsub_limb.sv
// Scoreboard bench for mp_addsub_limb: three instances (LIMB = 1, 64, 515) get the same directed vectors.
// A single monitor checks result, sub_taken, latency and busy length on every done pulse.
module tb_mp_addsub_limb;

  localparam int unsigned W  = 514;
  localparam int unsigned W1 = W + 1;
  localparam int          NI = 3;
  localparam int          LT  [NI] = '{1, 64, 515};
  localparam int          NLT [NI] = '{515, 9, 1};

  typedef struct {
    logic [W:0] res;
    logic       sub;
    logic       chk_sub;
    int         t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start_s [NI];
  logic [1:0]   mode_s;
  logic         shift_s;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic [W:0]   res_s  [NI];
  logic         busy_s [NI];
  logic         done_s [NI];
  logic         subt_s [NI];

  exp_t exp_q [NI][$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   bcnt [NI];

  logic [W-1:0] ONES, P513;
  logic [W:0]   P514, ALL, M513;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LG = (g == 0) ? 1 : ((g == 1) ? 64 : 515);
    mp_addsub_limb_if #(.WIDTH(W)) bus ();
    assign bus.start  = start_s[g];
    assign bus.mode   = mode_s;
    assign bus.shift  = shift_s;
    assign bus.in_a   = a_s;
    assign bus.in_b   = b_s;
    assign res_s[g]   = bus.result;
    assign busy_s[g]  = bus.busy;
    assign done_s[g]  = bus.done;
    assign subt_s[g]  = bus.sub_taken;
    mp_addsub_limb #(.WIDTH(W), .LIMB(LG)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
    );
  end

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      if (!resetn) begin
        bcnt[g] = 0;
      end else begin
        if (busy_s[g]) bcnt[g]++;
        if (done_s[g]) begin
          if (exp_q[g].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_done limb=%0d: got done with result %h expected no done", LT[g], res_s[g]);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("result limb=%0d", LT[g]), res_s[g], e.res);
            chk($sformatf("latency limb=%0d", LT[g]), W1'(cyc - e.t0 - 1), W1'(NLT[g] + 1));
            chk($sformatf("busy_len limb=%0d", LT[g]), W1'(bcnt[g]), W1'(NLT[g]));
            chk($sformatf("busy_at_done limb=%0d", LT[g]), W1'(busy_s[g]), W1'(0));
            if (e.chk_sub)
              chk($sformatf("sub_taken limb=%0d", LT[g]), W1'(subt_s[g]), W1'(e.sub));
          end
          bcnt[g] = 0;
        end
      end
    end
  end

  function automatic bit all_empty();
    for (int g = 0; g < NI; g++)
      if (exp_q[g].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain();
    for (int k = 0; k < 700; k++) begin
      if (all_empty()) break;
      @(negedge clk);
    end
    n_chk++;
    if (!all_empty()) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d/%0d pending expected 0",
               exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
      for (int g = 0; g < NI; g++) exp_q[g].delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W:0] r, input logic st, input logic cs);
    exp_t e;
    @(negedge clk);
    mode_s = m;
    a_s    = a;
    b_s    = b;
    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b1;
      e.res = r; e.sub = st; e.chk_sub = cs; e.t0 = cyc;
      exp_q[g].push_back(e);
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) start_s[g] = 1'b0;
    a_s    = ~a;
    b_s    = ~b;
    mode_s = ~m;
    wait_drain();
  endtask

  task automatic do_shift(input logic [W:0] r, input string nm);
    @(negedge clk);
    shift_s = 1'b1;
    @(negedge clk);
    shift_s = 1'b0;
    for (int g = 0; g < NI; g++) chk($sformatf("%s limb=%0d", nm, LT[g]), res_s[g], r);
  endtask

  initial begin
    exp_t e;
    ONES = '1;
    P513 = '0;  P513[513] = 1'b1;
    P514 = '0;  P514[W]   = 1'b1;
    ALL  = '1;
    M513 = {2'b00, {513{1'b1}}};

    resetn = 1'b0; shift_s = 1'b0; mode_s = 2'b00; a_s = '0; b_s = '0;
    for (int g = 0; g < NI; g++) start_s[g] = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_result limb=%0d", LT[g]), res_s[g], '0);
      chk($sformatf("rst_busy limb=%0d", LT[g]), W1'(busy_s[g]), W1'(0));
      chk($sformatf("rst_done limb=%0d", LT[g]), W1'(done_s[g]), W1'(0));
      chk($sformatf("rst_sub_taken limb=%0d", LT[g]), W1'(subt_s[g]), W1'(0));
    end
    resetn = 1'b1;
    @(negedge clk);

    op(2'b00, W'(1), W'(1), W1'(2), 1'b0, 1'b0);
    do_shift(W1'(1), "shift_2_to_1");
    op(2'b01, W'(1), W'(1), '0, 1'b0, 1'b0);
    op(2'b01, W'(1), W'(2), ALL, 1'b0, 1'b0);
    do_shift({1'b0, ONES}, "shift_all_ones");
    op(2'b00, ONES, W'(1), P514, 1'b0, 1'b0);
    op(2'b01, ONES, ONES, '0, 1'b0, 1'b0);
    op(2'b10, W'(7), W'(5), W1'(2), 1'b1, 1'b1);
    op(2'b10, W'(5), W'(7), W1'(5), 1'b0, 1'b1);
    op(2'b10, W'(16'h1234), W'(16'h1234), '0, 1'b1, 1'b1);
    op(2'b11, W'(3), W'(4), W1'(7), 1'b0, 1'b0);
    op(2'b00, ONES, ONES, {ONES, 1'b0}, 1'b0, 1'b0);
    op(2'b01, '0, ONES, P514 | W1'(1), 1'b0, 1'b0);
    op(2'b10, P513, W'(1), M513, 1'b1, 1'b1);
    op(2'b00, P513, P513, P514, 1'b0, 1'b0);

    // Start pulsed while busy (LIMB=64 only): must be dropped.
    @(negedge clk);
    mode_s = 2'b00; a_s = W'(1); b_s = W'(1);
    start_s[1] = 1'b1;
    e.res = W1'(2); e.sub = 1'b0; e.chk_sub = 1'b0; e.t0 = cyc;
    exp_q[1].push_back(e);
    @(negedge clk);
    start_s[1] = 1'b0; a_s = '0; b_s = '0;
    @(negedge clk);
    @(negedge clk);
    start_s[1] = 1'b1; mode_s = 2'b01; a_s = W'(9); b_s = W'(3);
    @(negedge clk);
    start_s[1] = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    chk("ignored_start_result", res_s[1], W1'(2));

    // Reset in the middle of an operation: discarded, no done afterwards.
    @(negedge clk);
    mode_s = 2'b00; a_s = ONES; b_s = W'(1);
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("midrst_result limb=%0d", LT[g]), res_s[g], '0);
      chk($sformatf("midrst_busy limb=%0d", LT[g]), W1'(busy_s[g]), W1'(0));
    end
    @(negedge clk);
    #2 resetn = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_no_done_result", res_s[1], '0);

    for (int g = 0; g < NI; g++)
      chk($sformatf("queue_empty limb=%0d", LT[g]), W1'(exp_q[g].size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
